// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the popcount accumulator.
package popcnt_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam logic MODE_PLAIN = 1'b0;
  localparam logic MODE_XNOR  = 1'b1;

  // Bits needed to hold a count of 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of N bits, built recursively.
// Leaves are a wire (1 bit), a half adder (2 bits) or a full adder (3 bits);
// larger inputs split in two halves whose counts are summed.
module popcount_tree
  import popcnt_pkg::*;
#(
  parameter int N     = 14,
  parameter int CNT_W = cnt_w(N)
) (
  input  logic [N-1:0]     bits_i,
  output logic [CNT_W-1:0] count_o
);

  if (N == 1) begin : g_wire
    assign count_o = bits_i;
  end else if (N == 2) begin : g_ha
    assign count_o = {bits_i[0] & bits_i[1], bits_i[0] ^ bits_i[1]};
  end else if (N == 3) begin : g_fa
    logic p;
    assign p       = bits_i[0] ^ bits_i[1];
    assign count_o = {(bits_i[0] & bits_i[1]) | (bits_i[2] & p), p ^ bits_i[2]};
  end else begin : g_split
    localparam int NL  = N / 2;
    localparam int NH  = N - NL;
    localparam int CWL = cnt_w(NL);
    localparam int CWH = cnt_w(NH);
    logic [CWL-1:0] cnt_lo;
    logic [CWH-1:0] cnt_hi;

    popcount_tree #(.N(NL), .CNT_W(CWL)) u_lo (
      .bits_i  (bits_i[NL-1:0]),
      .count_o (cnt_lo)
    );

    popcount_tree #(.N(NH), .CNT_W(CWH)) u_hi (
      .bits_i  (bits_i[N-1:NL]),
      .count_o (cnt_hi)
    );

    assign count_o = CNT_W'(cnt_lo) + CNT_W'(cnt_hi);
  end

endmodule

// File: rtl/popcount_accum.sv
// Pipelined popcount accumulator: one S1 count stage feeding an ACC/DONE FSM
// that sums counts over a group delimited by in_last.
// Build option: define POPCNT_SAT_EN to saturate the accumulator on overflow
// instead of wrapping; out_ovf reports the overflow either way.
module popcount_accum
  import popcnt_pkg::*;
#(
  parameter int N_IN  = 14,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic [N_IN-1:0]  in_weight,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = cnt_w(N_IN);

  state_e           state_q, state_d;
  logic             grp_first_q, grp_first_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic             eff_mode;
  logic [N_IN-1:0]  sel_vec;
  logic [CNT_W-1:0] tree_cnt;
  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  // The first beat of a group uses the live mode; later beats use the latched one.
  assign eff_mode = grp_first_q ? in_mode : mode_q;
  assign sel_vec  = (eff_mode == MODE_XNOR) ? ~(in_data ^ in_weight) : in_data;

  popcount_tree #(.N(N_IN), .CNT_W(CNT_W)) u_tree (
    .bits_i  (sel_vec),
    .count_o (tree_cnt)
  );

  assign in_ready  = !s1_valid_q || (state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  // acc is zeroed on reset and on each result handshake, so every group starts from zero.
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(s1_cnt_q);
  assign carry   = sum_ext[ACC_W];
`ifdef POPCNT_SAT_EN
  assign acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  // Next-state logic: S1 load/drain, mode latch, ACC/DONE FSM and result register.
  always_comb begin
    state_d     = state_q;
    grp_first_d = grp_first_q;
    mode_d      = mode_q;
    s1_cnt_d    = s1_cnt_q;
    s1_last_d   = s1_last_q;
    s1_valid_d  = s1_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      ACC: begin
        if (s1_valid_q) begin
          acc_d      = acc_next;
          ovf_d      = ovf_q | carry;
          s1_valid_d = 1'b0;
          if (s1_last_q) begin
            out_sum_d   = acc_next;
            out_ovf_d   = ovf_q | carry;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase

    // A new beat overrides the drain above: S1 is refilled in the same cycle it empties.
    if (accept) begin
      s1_cnt_d    = tree_cnt;
      s1_last_d   = in_last;
      s1_valid_d  = 1'b1;
      grp_first_d = in_last;
      if (grp_first_q) mode_d = in_mode;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACC;
      grp_first_q <= 1'b1;
      mode_q      <= MODE_PLAIN;
      s1_cnt_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_first_q <= grp_first_d;
      mode_q      <= mode_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Directed bench for popcount_accum: a 16-bit accumulator instance for the
// functional scenarios and a 4-bit one sharing the same inputs for overflow.
module tb_popcount_accum;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_mode, in_last, out_ready;
  logic [13:0] in_data, in_weight;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic        in_ready4, out_valid4, out_ovf4;
  logic [3:0]  out_sum4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  popcount_accum #(.N_IN(14), .ACC_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  popcount_accum #(.N_IN(14), .ACC_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_weight(in_weight), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready), .out_sum(out_sum4), .out_ovf(out_ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded); reports acceptance.
  task automatic send_beat(input logic [13:0] d, input logic [13:0] w,
                           input logic m, input logic l, output bit ok);
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_mode   = m;
    in_last   = l;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for out_valid, bounded; ok=0 if it never came.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_weight = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sum !== 16'd0) begin bad++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
  endtask

  task automatic test_plain();
    bit ok;
    out_ready = 1'b1;
    send_beat(14'h3FFF, 14'h0000, 1'b0, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL plain_accept got=timeout exp=accepted"); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL plain_early_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL plain_latency got=%b exp=1", out_valid); end
    total++; if (out_sum !== 16'd14) begin bad++; $display("FAIL plain_sum got=%0d exp=14", out_sum); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL plain_ovf got=%b exp=0", out_ovf); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL plain_handshake got=%b exp=0", out_valid); end
  endtask

  task automatic test_xnor();
    bit ok, ok1, ok2;
    logic [13:0] w, flip;
    w    = 14'h2A5C;
    flip = 14'h3F80;
    out_ready = 1'b1;
    send_beat(w, w, 1'b1, 1'b0, ok);
    send_beat(~w, w, 1'b1, 1'b0, ok1);
    send_beat(w ^ flip, w, 1'b1, 1'b1, ok2);
    wait_valid(ok);
    total++; if (!(ok && ok1 && ok2)) begin bad++; $display("FAIL xnor_flow got=timeout exp=result"); end
    total++; if (out_sum !== 16'd21) begin bad++; $display("FAIL xnor_sum got=%0d exp=21", out_sum); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL xnor_ovf got=%b exp=0", out_ovf); end
    tick();
  endtask

  task automatic test_mode_latch();
    bit ok, ok1;
    out_ready = 1'b1;
    send_beat(14'h0001, 14'h0000, 1'b0, 1'b0, ok);
    send_beat(14'h0001, 14'h0000, 1'b1, 1'b1, ok1);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL mode_latch_valid got=timeout exp=result"); end
    total++; if (out_sum !== 16'd2) begin bad++; $display("FAIL mode_latch_sum got=%0d exp=2", out_sum); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok, ok1;
    out_ready = 1'b0;
    send_beat(14'h00FF, 14'h0000, 1'b0, 1'b0, ok);
    send_beat(14'h0003, 14'h0000, 1'b0, 1'b1, ok1);
    wait_valid(ok);
    total++; if (!(ok && ok1)) begin bad++; $display("FAIL bp_first_result got=timeout exp=result"); end
    send_beat(14'h0007, 14'h0000, 1'b0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_fill_s1 got=timeout exp=accepted"); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_sum !== 16'd10) begin
        bad++;
        $display("FAIL bp_hold[%0d] got valid=%b sum=%0d exp valid=1 sum=10", i, out_valid, out_sum);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    send_beat(14'h0001, 14'h0000, 1'b0, 1'b1, ok);
    wait_valid(ok1);
    total++; if (!(ok && ok1)) begin bad++; $display("FAIL bp_second_result got=timeout exp=result"); end
    total++; if (out_sum !== 16'd4) begin bad++; $display("FAIL bp_second_sum got=%0d exp=4", out_sum); end
    tick();
  endtask

  task automatic test_overflow();
    bit ok, ok1;
    logic [3:0] exp4;
`ifdef POPCNT_SAT_EN
    exp4 = 4'd15;
`else
    exp4 = 4'd12;
`endif
    out_ready = 1'b1;
    send_beat(14'h3FFF, 14'h0000, 1'b0, 1'b0, ok);
    send_beat(14'h3FFF, 14'h0000, 1'b0, 1'b1, ok1);
    wait_valid(ok);
    total++; if (!(ok && ok1 && out_valid4)) begin bad++; $display("FAIL ovf_valid got=%b exp=1", out_valid4); end
    total++; if (out_sum4 !== exp4) begin bad++; $display("FAIL ovf_sum4 got=%0d exp=%0d", out_sum4, exp4); end
    total++; if (out_ovf4 !== 1'b1) begin bad++; $display("FAIL ovf_flag4 got=%b exp=1", out_ovf4); end
    total++; if (out_sum !== 16'd28 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_wide got sum=%0d ovf=%b exp sum=28 ovf=0", out_sum, out_ovf);
    end
    tick();
    // A following group must start with a clear overflow flag.
    send_beat(14'h0003, 14'h0000, 1'b0, 1'b1, ok);
    wait_valid(ok1);
    total++; if (out_sum4 !== 4'd2 || out_ovf4 !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got sum=%0d ovf=%b exp sum=2 ovf=0", out_sum4, out_ovf4);
    end
    tick();
  endtask

  task automatic test_reset_mid_group();
    bit ok, ok1, seen;
    out_ready = 1'b1;
    send_beat(14'h00FF, 14'h0000, 1'b1, 1'b0, ok);
    send_beat(14'h00FF, 14'h0000, 1'b1, 1'b0, ok1);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    total++; if (seen) begin bad++; $display("FAIL rst_mid_no_output got=valid exp=none"); end
    send_beat(14'h000F, 14'h0000, 1'b0, 1'b1, ok);
    wait_valid(ok1);
    total++; if (!ok1) begin bad++; $display("FAIL rst_mid_after_valid got=timeout exp=result"); end
    total++; if (out_sum !== 16'd4) begin bad++; $display("FAIL rst_mid_after_sum got=%0d exp=4", out_sum); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plain();
    test_xnor();
    test_mode_latch();
    test_backpressure();
    test_overflow();
    test_reset_mid_group();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
